// File: rtl/dp_exmpl_rtl_pkg.sv
// Shared definitions for the design-example datapath, its controller and the bench.
// Default counter geometry, controller state codes, and the control-strobe bundle
// together with the helper that flags illegal strobe combinations.
package dp_exmpl_rtl_pkg;

  localparam int A_W_DEF  = 4;
  localparam int TAP2_DEF = 2;
  localparam int TAP3_DEF = 3;

  // Controller state codes; S_2 is 2'b11 so S_idle -> S_1 -> S_2 only ever flips one bit.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_1    = 2'b01,
    S_2    = 2'b11
  } ctrl_state_e;

  typedef struct packed {
    logic set_e;
    logic clr_e;
    logic set_f;
    logic clr_a_f;
    logic incr_a;
  } dp_ctl_t;

  // Strobe pairs that request contradictory updates in the same cycle.
  function automatic logic ctl_conflict(input dp_ctl_t c);
    return (c.set_e & c.clr_e) | (c.set_f & c.clr_a_f) | (c.incr_a & c.clr_a_f);
  endfunction

endpackage

// File: rtl/dp_exmpl_rtl_cnt.sv
// cnt_rtl: W-bit counter with synchronous clear and increment, plus a registered
// one-cycle wrap pulse that follows an increment from all-ones back to zero.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_clr           q <= 0 next edge (wins over i_inc)
//   i_inc           q <= q + 1 next edge (modulo 2^W)
//   o_q             counter value
//   o_wrap          high for one cycle after the all-ones -> 0 increment
module cnt_rtl #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q,
  output logic         o_wrap
);

  logic [W-1:0] r_q;
  logic         r_wrap;
  logic         w_inc_eff;

  // A clear overrides the increment, so an overridden increment can never wrap.
  assign w_inc_eff = i_inc & ~i_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (i_clr)          r_q <= '0;
      else if (w_inc_eff) r_q <= r_q + 1'b1;
      r_wrap <= w_inc_eff & (&r_q);
    end
  end

  assign o_q    = r_q;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/dp_exmpl_rtl.sv
// dp_exmpl_rtl: datapath beside the design-example controller. Consumes the control
// strobes, holds counter A and flags E/F, and returns the status bits the controller
// branches on. All outputs come straight from registers (no input-to-output path).
// Ports:
//   clk_i, rst_b_i                   clock, async active-low reset
//   set_E_i, clr_E_i                 E control (both or neither -> hold)
//   set_F_i, clr_A_F_i, incr_A_i     F / A control (clr_A_F_i has top priority)
//   A_o, E_o, F_o                    register state
//   A2_o, A3_o                       taps A[TAP2], A[TAP3]
//   wrap_o                           one-cycle pulse after A wraps via increment
//   done_o                           one-cycle pulse after F rises
//   err_o                            sticky conflicting-strobe flag, cleared by reset only
module dp_exmpl_rtl
  import dp_exmpl_rtl_pkg::*;
#(
  parameter int A_W  = A_W_DEF,
  parameter int TAP2 = TAP2_DEF,
  parameter int TAP3 = TAP3_DEF
) (
  input  logic           clk_i,
  input  logic           rst_b_i,
  input  logic           set_E_i,
  input  logic           clr_E_i,
  input  logic           set_F_i,
  input  logic           clr_A_F_i,
  input  logic           incr_A_i,
  output logic [A_W-1:0] A_o,
  output logic           E_o,
  output logic           F_o,
  output logic           A2_o,
  output logic           A3_o,
  output logic           wrap_o,
  output logic           done_o,
  output logic           err_o
);

  dp_ctl_t        w_ctl;
  logic [A_W-1:0] w_a;
  logic           w_wrap;
  logic           w_f_nxt;
  logic           r_e;
  logic           r_f;
  logic           r_done;
  logic           r_err;

  assign w_ctl = '{set_e:   set_E_i,
                   clr_e:   clr_E_i,
                   set_f:   set_F_i,
                   clr_a_f: clr_A_F_i,
                   incr_a:  incr_A_i};

  cnt_rtl #(.W(A_W)) u_cnt_a (
    .i_clk   (clk_i),
    .i_rst_n (rst_b_i),
    .i_clr   (w_ctl.clr_a_f),
    .i_inc   (w_ctl.incr_a),
    .o_q     (w_a),
    .o_wrap  (w_wrap)
  );

  always_comb begin
    w_f_nxt = r_f;
    if (w_ctl.clr_a_f)    w_f_nxt = 1'b0;
    else if (w_ctl.set_f) w_f_nxt = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      r_e    <= 1'b0;
      r_f    <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      // Simultaneous set and clear of E is a conflict; hold rather than pick a winner.
      case ({w_ctl.set_e, w_ctl.clr_e})
        2'b10:   r_e <= 1'b1;
        2'b01:   r_e <= 1'b0;
        default: r_e <= r_e;
      endcase
      r_f    <= w_f_nxt;
      r_done <= w_f_nxt & ~r_f;
      r_err  <= r_err | ctl_conflict(w_ctl);
    end
  end

  assign A_o    = w_a;
  assign A2_o   = w_a[TAP2];
  assign A3_o   = w_a[TAP3];
  assign E_o    = r_e;
  assign F_o    = r_f;
  assign wrap_o = w_wrap;
  assign done_o = r_done;
  assign err_o  = r_err;

endmodule
